// File: rtl/hazard_unit.sv
// Stall and operand-forwarding control for the 5-stage core.
// Define HAZARD_W_FWD_EN to let D-stage operands forward from W (select 3).
module hazard_unit #(
  parameter int TW = 3,
  parameter int RW = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [RW-1:0] rs_D,
  input  logic [RW-1:0] rt_D,
  input  logic [TW-1:0] tuse_Drs,
  input  logic [TW-1:0] tuse_Drt,
  input  logic [TW-1:0] tnew_D,
  input  logic          rfwe_D,
  input  logic [RW-1:0] wreg_D,
  output logic          stall,
  output logic [1:0]    fwd_rs_D,
  output logic [1:0]    fwd_rt_D,
  output logic [1:0]    fwd_rs_E,
  output logic [1:0]    fwd_rt_E,
  output logic          fwd_rt_M
);

`ifdef HAZARD_W_FWD_EN
  localparam logic W_FWD = 1'b1;
`else
  localparam logic W_FWD = 1'b0;
`endif

  logic [RW-1:0] rs_e_q, rs_e_d, rt_e_q, rt_e_d;
  logic [RW-1:0] wreg_e_q, wreg_e_d;
  logic          rfwe_e_q, rfwe_e_d;
  logic [TW-1:0] tnew_e_q, tnew_e_d;
  logic [RW-1:0] rt_m_q, rt_m_d, wreg_m_q, wreg_m_d;
  logic          rfwe_m_q, rfwe_m_d;
  logic [TW-1:0] tnew_m_q, tnew_m_d;
  logic [RW-1:0] wreg_w_q, wreg_w_d;
  logic          rfwe_w_q, rfwe_w_d;

  function automatic logic [TW-1:0] dec_sat(
    input logic [TW-1:0] t
  );
    return (t == '0) ? '0 : t - TW'(1);
  endfunction

  function automatic logic hit(
    input logic          we,
    input logic [RW-1:0] w,
    input logic [RW-1:0] r
  );
    return we && (w == r) && (r != '0);
  endfunction

  // Youngest matching producer decides; an unready one
  // yields 0 because the stall covers that case.
  function automatic logic [1:0] sel_d(
    input logic he, input logic re,
    input logic hm, input logic rm,
    input logic hw
  );
    if (he)      return re ? 2'd2 : 2'd0;
    else if (hm) return rm ? 2'd1 : 2'd0;
    else         return (hw && W_FWD) ? 2'd3 : 2'd0;
  endfunction

  function automatic logic [1:0] sel_e(
    input logic hm, input logic rm,
    input logic hw
  );
    if (hm)      return rm ? 2'd1 : 2'd0;
    else if (hw) return 2'd2;
    else         return 2'd0;
  endfunction

  logic e_rs, e_rt, m_rs, m_rt, w_rs, w_rt;
  logic rdy_e, rdy_m;

  always_comb begin
    e_rs  = hit(rfwe_e_q, wreg_e_q, rs_D);
    e_rt  = hit(rfwe_e_q, wreg_e_q, rt_D);
    m_rs  = hit(rfwe_m_q, wreg_m_q, rs_D);
    m_rt  = hit(rfwe_m_q, wreg_m_q, rt_D);
    w_rs  = hit(rfwe_w_q, wreg_w_q, rs_D);
    w_rt  = hit(rfwe_w_q, wreg_w_q, rt_D);
    rdy_e = (tnew_e_q == '0);
    rdy_m = (tnew_m_q == '0);

    stall = (e_rs && (tuse_Drs < tnew_e_q))
          | (m_rs && (tuse_Drs < tnew_m_q))
          | (e_rt && (tuse_Drt < tnew_e_q))
          | (m_rt && (tuse_Drt < tnew_m_q));

    fwd_rs_D = sel_d(e_rs, rdy_e, m_rs, rdy_m, w_rs);
    fwd_rt_D = sel_d(e_rt, rdy_e, m_rt, rdy_m, w_rt);

    fwd_rs_E = sel_e(hit(rfwe_m_q, wreg_m_q, rs_e_q), rdy_m,
                     hit(rfwe_w_q, wreg_w_q, rs_e_q));
    fwd_rt_E = sel_e(hit(rfwe_m_q, wreg_m_q, rt_e_q), rdy_m,
                     hit(rfwe_w_q, wreg_w_q, rt_e_q));
    fwd_rt_M = hit(rfwe_w_q, wreg_w_q, rt_m_q);
  end

  always_comb begin
    rs_e_d   = rs_D;
    rt_e_d   = rt_D;
    wreg_e_d = wreg_D;
    rfwe_e_d = rfwe_D;
    tnew_e_d = dec_sat(tnew_D);
    if (stall) begin
      rs_e_d   = '0;
      rt_e_d   = '0;
      wreg_e_d = '0;
      rfwe_e_d = 1'b0;
      tnew_e_d = '0;
    end
    rt_m_d   = rt_e_q;
    wreg_m_d = wreg_e_q;
    rfwe_m_d = rfwe_e_q;
    tnew_m_d = dec_sat(tnew_e_q);
    wreg_w_d = wreg_m_q;
    rfwe_w_d = rfwe_m_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rs_e_q   <= '0;
      rt_e_q   <= '0;
      wreg_e_q <= '0;
      rfwe_e_q <= 1'b0;
      tnew_e_q <= '0;
      rt_m_q   <= '0;
      wreg_m_q <= '0;
      rfwe_m_q <= 1'b0;
      tnew_m_q <= '0;
      wreg_w_q <= '0;
      rfwe_w_q <= 1'b0;
    end else begin
      rs_e_q   <= rs_e_d;
      rt_e_q   <= rt_e_d;
      wreg_e_q <= wreg_e_d;
      rfwe_e_q <= rfwe_e_d;
      tnew_e_q <= tnew_e_d;
      rt_m_q   <= rt_m_d;
      wreg_m_q <= wreg_m_d;
      rfwe_m_q <= rfwe_m_d;
      tnew_m_q <= tnew_m_d;
      wreg_w_q <= wreg_w_d;
      rfwe_w_q <= rfwe_w_d;
    end
  end

endmodule

// File: tb/tb_hazard_unit.sv
// Bench for hazard_unit: directed pipeline scenarios plus random
// instruction streams checked against an instruction-history model.
module tb_hazard_unit;

`ifdef HAZARD_W_FWD_EN
  localparam int WFWD = 1;
`else
  localparam int WFWD = 0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [4:0] rs_D = '0, rt_D = '0, wreg_D = '0;
  logic [2:0] tuse_Drs = 3'd5, tuse_Drt = 3'd5, tnew_D = '0;
  logic       rfwe_D = 1'b0;
  logic       stall, fwd_rt_M;
  logic [1:0] fwd_rs_D, fwd_rt_D, fwd_rs_E, fwd_rt_E;

  int n_chk = 0;
  int n_fail = 0;

  hazard_unit #(.TW(3), .RW(5)) dut (
    .clk(clk), .reset(reset),
    .rs_D(rs_D), .rt_D(rt_D),
    .tuse_Drs(tuse_Drs), .tuse_Drt(tuse_Drt),
    .tnew_D(tnew_D), .rfwe_D(rfwe_D), .wreg_D(wreg_D),
    .stall(stall),
    .fwd_rs_D(fwd_rs_D), .fwd_rt_D(fwd_rt_D),
    .fwd_rs_E(fwd_rs_E), .fwd_rt_E(fwd_rt_E),
    .fwd_rt_M(fwd_rt_M)
  );

  always #5 clk = ~clk;

  // Instruction history: hist[k] issued k cycles ago (1=E, 2=M, 3=W).
  typedef struct packed {
    logic [4:0] rs, rt, wreg;
    logic       we;
    logic [2:0] tnew;
  } ins_t;
  ins_t hist [1:3];

  function automatic bit hitk(input int k, input logic [4:0] r);
    return hist[k].we && hist[k].wreg == r && r != 0;
  endfunction

  function automatic int rem(input int k);
    int t;
    if (k == 3) return 0;
    t = int'(hist[k].tnew) - k;
    return (t < 0) ? 0 : t;
  endfunction

  function automatic bit m_stall();
    bit s;
    s = 0;
    for (int k = 1; k <= 2; k++) begin
      if (hitk(k, rs_D) && int'(tuse_Drs) < rem(k)) s = 1;
      if (hitk(k, rt_D) && int'(tuse_Drt) < rem(k)) s = 1;
    end
    return s;
  endfunction

  task automatic exp_fd(input logic [4:0] r, output int v, output bit ok);
    bit found;
    v = 0; ok = 1; found = 0;
    for (int k = 1; k <= 3; k++) begin
      if (!found && hitk(k, r)) begin
        found = 1;
        if (k == 3) v = WFWD ? 3 : 0;
        else if (rem(k) == 0) v = (k == 1) ? 2 : 1;
        else ok = 0;
      end
    end
  endtask

  task automatic exp_fe(input logic [4:0] r, output int v, output bit ok);
    v = 0; ok = 1;
    if (hitk(2, r)) begin
      if (rem(2) == 0) v = 1;
      else ok = 0;
    end else if (hitk(3, r)) v = 2;
  endtask

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, got, exp, $time);
    end
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 1; k <= 3; k++) hist[k] = '0;
    end else begin
      bit s;
      s = m_stall();
      hist[3] = hist[2];
      hist[2] = hist[1];
      if (s) hist[1] = '0;
      else hist[1] = '{rs: rs_D, rt: rt_D, wreg: wreg_D,
                       we: rfwe_D, tnew: tnew_D};
    end
  end

  always @(negedge clk) begin
    bit s, ok;
    int v;
    s = m_stall();
    chk("stall", 32'(stall), 32'(s));
    if (!s) begin
      exp_fd(rs_D, v, ok);
      if (ok) chk("fwd_rs_D", 32'(fwd_rs_D), v);
      exp_fd(rt_D, v, ok);
      if (ok) chk("fwd_rt_D", 32'(fwd_rt_D), v);
    end
    exp_fe(hist[1].rs, v, ok);
    if (ok) chk("fwd_rs_E", 32'(fwd_rs_E), v);
    exp_fe(hist[1].rt, v, ok);
    if (ok) chk("fwd_rt_E", 32'(fwd_rt_E), v);
    chk("fwd_rt_M", 32'(fwd_rt_M), 32'(hitk(3, hist[2].rt)));
  end

  task automatic issue(input int rs, input int rt, input int tur,
                       input int tut, input int tn, input int we,
                       input int wr);
    @(posedge clk);
    #2;
    rs_D = 5'(rs); rt_D = 5'(rt);
    tuse_Drs = 3'(tur); tuse_Drt = 3'(tut);
    tnew_D = 3'(tn); rfwe_D = 1'(we); wreg_D = 5'(wr);
  endtask

  task automatic nop();
    issue(0, 0, 5, 5, 0, 0, 0);
  endtask

  task automatic hold();
    @(posedge clk);
    #2;
  endtask

  task automatic all_zero(input string nm);
    chk({nm, "_stall"}, 32'(stall), 0);
    chk({nm, "_fwd"}, {21'd0, fwd_rs_D, fwd_rt_D, fwd_rs_E,
                       fwd_rt_E, fwd_rt_M}, 0);
  endtask

  initial begin
    int tus [4];
    tus = '{0, 1, 2, 5};
    #1;
    all_zero("reset_state");
    @(posedge clk);
    #2 reset = 1'b0;

    // mid-stream reset with lw $1 in E and a dependent addu in D
    issue(2, 1, 1, 5, 3, 1, 1);
    issue(1, 3, 1, 1, 2, 1, 2);
    #1 chk("t1_pre_stall", 32'(stall), 1);
    reset = 1'b1;
    #1 all_zero("t1_async");
    @(posedge clk);
    #2 reset = 1'b0;
    @(negedge clk) chk("t1_post", 32'(stall), 0);

    // load-use: one bubble, then W forwarding into E
    issue(2, 1, 1, 5, 3, 1, 1);
    issue(1, 3, 1, 1, 2, 1, 2);
    @(negedge clk) chk("t2_stall", 32'(stall), 1);
    hold();
    @(negedge clk) chk("t2_release", 32'(stall), 0);
    hold();
    @(negedge clk) chk("t2_fwd_rs_E", 32'(fwd_rs_E), 2);
    nop();

    // branch in D waits for ALU result, then takes it from M
    issue(2, 3, 1, 1, 2, 1, 4);
    issue(4, 0, 0, 0, 0, 0, 0);
    @(negedge clk) chk("t3_stall", 32'(stall), 1);
    hold();
    @(negedge clk) begin
      chk("t3_release", 32'(stall), 0);
      chk("t3_fwd_rs_D", 32'(fwd_rs_D), 1);
    end
    nop();

    // jal then jr $31
    issue(0, 0, 5, 5, 0, 1, 31);
    issue(31, 0, 0, 5, 0, 0, 0);
    @(negedge clk) begin
      chk("t4_stall", 32'(stall), 0);
      chk("t4_fwd_rs_D", 32'(fwd_rs_D), 2);
    end

    // lw feeding sw data, forwarded late at M
    issue(6, 5, 1, 5, 3, 1, 5);
    issue(6, 5, 1, 2, 0, 0, 0);
    @(negedge clk) chk("t5_stall", 32'(stall), 0);
    nop();
    nop();
    @(negedge clk) chk("t5_fwd_rt_M", 32'(fwd_rt_M), 1);

    // $0 destinations never forward; W forwarding build option
    issue(0, 0, 1, 5, 2, 1, 0);
    issue(0, 0, 1, 1, 2, 1, 7);
    @(negedge clk) begin
      chk("t6_stall", 32'(stall), 0);
      chk("t6_fwd_rs_D", 32'(fwd_rs_D), 0);
      chk("t6_fwd_rt_D", 32'(fwd_rt_D), 0);
    end
    issue(0, 8, 5, 5, 2, 1, 8);
    nop();
    nop();
    issue(8, 0, 1, 1, 2, 1, 9);
    @(negedge clk) begin
      chk("t6_w_stall", 32'(stall), 0);
      chk("t6_w_fwd_rs_D", 32'(fwd_rs_D), WFWD ? 3 : 0);
    end

    for (int i = 0; i < 3000; i++) begin
      issue($urandom_range(0, 3), $urandom_range(0, 3),
            tus[$urandom_range(0, 3)], tus[$urandom_range(0, 3)],
            $urandom_range(0, 3), $urandom_range(0, 1),
            $urandom_range(0, 3));
      if ($urandom_range(0, 150) == 0) begin
        #1 reset = 1'b1;
        #1 all_zero("rand_async");
        @(posedge clk);
        #2 reset = 1'b0;
      end
    end
    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
